// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter and its arbiter: op encodings, request struct,
// arbiter FSM states and the illegal-op predicate.
package shifter_pkg;

    localparam logic [1:0] SEL_LEFT   = 2'd0;
    localparam logic [1:0] SEL_RIGHT  = 2'd1;
    localparam logic [1:0] SEL_SEXT8  = 2'd2;
    localparam logic [1:0] SEL_SEXT16 = 2'd3;

    typedef struct packed {
        logic [31:0] IN;
        logic [4:0]  SHFT;
        logic [1:0]  SEL;
        logic        ARITH;
    } shift_req_t;

    typedef enum logic {StEmpty, StFull} arb_state_e;

    // Left with ARITH, or any sign-extend carrying a shift amount or ARITH.
    function automatic logic op_illegal(input shift_req_t r);
        logic is_sext;
        is_sext = (r.SEL == SEL_SEXT8) || (r.SEL == SEL_SEXT16);
        return ((r.SEL == SEL_LEFT) && r.ARITH) ||
               (is_sext && ((r.SHFT != 5'd0) || r.ARITH));
    endfunction

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit shifter: left, logical/arithmetic right, sign-extend byte/half.
// Output is forced to zero while N_RST is low.
module shifter
    import shifter_pkg::*;
(
    input  logic        N_RST,
    input  shift_req_t  REQ,
    output logic [31:0] OUT
);

    logic [31:0] res;

    // Decode the op and form the result.
    always_comb begin
        res = '0;
        unique case (REQ.SEL)
            SEL_LEFT:   res = REQ.IN << REQ.SHFT;
            SEL_RIGHT:  res = REQ.ARITH ? 32'($signed(REQ.IN) >>> REQ.SHFT)
                                        : (REQ.IN >> REQ.SHFT);
            SEL_SEXT8:  res = {{24{REQ.IN[7]}}, REQ.IN[7:0]};
            SEL_SEXT16: res = {{16{REQ.IN[15]}}, REQ.IN[15:0]};
            default:    res = '0;
        endcase
        OUT = N_RST ? res : '0;
    end

endmodule

// File: rtl/shifter_arb.sv
// Round-robin arbiter sharing one shifter between NREQ requesters, with a single
// registered result slot (EMPTY/FULL) and drain-and-refill in one cycle.
// Optional feature macro: SHIFTER_ARB_CHECK_EN (flags and sanitizes illegal ops via ERR).
module shifter_arb
    import shifter_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IDW = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ-1:0][31:0] REQ_IN,
    input  logic [NREQ-1:0][4:0]  REQ_SHFT,
    input  logic [NREQ-1:0][1:0]  REQ_SEL,
    input  logic [NREQ-1:0]       REQ_ARITH,
    output logic [NREQ-1:0]       REQ_ACK,
    output logic [31:0]           OUT,
    output logic [IDW-1:0]        OUT_ID,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  ERR
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic           found;
    int unsigned    idx;
    logic           allow;
    logic           accept;
    shift_req_t     sel_req, drv_req;
    logic           illegal;
    logic [31:0]    shift_out;

    // Round-robin pick: first valid requester at or after the pointer.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!found && REQ_VALID[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_idx    = IDW'(idx);
            end
        end
        allow   = (state_q == StEmpty) || OUT_READY;
        accept  = found && allow && !RST;
        REQ_ACK = accept ? gnt : '0;
    end

    // Pointer moves past the winner only when a grant is issued.
    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Route granted operands to the shifter; idle drive is requester 0, left by 0.
    always_comb begin
        sel_req.IN    = REQ_IN[0];
        sel_req.SHFT  = 5'd0;
        sel_req.SEL   = SEL_LEFT;
        sel_req.ARITH = 1'b0;
        if (accept) begin
            sel_req.IN    = REQ_IN[gnt_idx];
            sel_req.SHFT  = REQ_SHFT[gnt_idx];
            sel_req.SEL   = REQ_SEL[gnt_idx];
            sel_req.ARITH = REQ_ARITH[gnt_idx];
        end
    end

`ifdef SHIFTER_ARB_CHECK_EN
    // Flag illegal ops and drive the shifter with the sanitized form.
    always_comb begin
        illegal = op_illegal(sel_req);
        drv_req = sel_req;
        if (illegal) begin
            drv_req.ARITH = 1'b0;
            if (sel_req.SEL[1]) begin
                drv_req.SHFT = 5'd0;
            end
        end
    end
`else
    // Pass operands through; ERR never set.
    always_comb begin
        illegal = 1'b0;
        drv_req = sel_req;
    end
`endif

    shifter u_shifter (
        .N_RST (~RST),
        .REQ   (drv_req),
        .OUT   (shift_out)
    );

    // State and pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StEmpty;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: fill on accept, drain on ready without refill.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (accept) state_d = StFull;
            StFull:  if (OUT_READY && !accept) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // Output valid mirrors the FULL state.
    always_comb begin
        OUT_VALID = (state_q == StFull);
    end

    // Result slot captures shifter output, owner and error on the accepting edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT    <= '0;
            OUT_ID <= '0;
            ERR    <= 1'b0;
        end else if (accept) begin
            OUT    <= shift_out;
            OUT_ID <= gnt_idx;
            ERR    <= illegal;
        end
    end

endmodule

// File: tb/tb_shifter_arb.sv
// Directed bench for shifter_arb (NREQ = 2) with hand-computed expected values.
module tb_shifter_arb;
    import shifter_pkg::*;

    logic            CLK = 1'b0;
    logic            RST;
    logic [1:0]      REQ_VALID;
    logic [1:0][31:0] REQ_IN;
    logic [1:0][4:0] REQ_SHFT;
    logic [1:0][1:0] REQ_SEL;
    logic [1:0]      REQ_ARITH;
    logic [1:0]      REQ_ACK;
    logic [31:0]     OUT;
    logic [0:0]      OUT_ID;
    logic            OUT_VALID;
    logic            OUT_READY;
    logic            ERR;

    int n_tests = 0;
    int n_fail  = 0;

    shifter_arb #(.NREQ(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_IN    (REQ_IN),
        .REQ_SHFT  (REQ_SHFT),
        .REQ_SEL   (REQ_SEL),
        .REQ_ARITH (REQ_ARITH),
        .REQ_ACK   (REQ_ACK),
        .OUT       (OUT),
        .OUT_ID    (OUT_ID),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] d,
                           input logic [4:0] s, input logic [1:0] op, input logic a);
        REQ_VALID[i] = v;
        REQ_IN[i]    = d;
        REQ_SHFT[i]  = s;
        REQ_SEL[i]   = op;
        REQ_ARITH[i] = a;
    endtask

    logic [31:0] exp_err;
    logic [1:0]  exp_ack [4];
    logic [31:0] exp_out [4];

    initial begin
        RST = 1'b1;
        OUT_READY = 1'b1;
        set_req(0, 1'b1, 32'h0, 5'd0, SEL_LEFT, 1'b0);
        set_req(1, 1'b0, 32'h0, 5'd0, SEL_LEFT, 1'b0);
        #2;
        // Reset state, ACK held low even with a valid request.
        check_eq("rst_ack", 32'(REQ_ACK), 32'h0);
        check_eq("rst_valid", 32'(OUT_VALID), 32'h0);
        check_eq("rst_out", OUT, 32'h0);
        check_eq("rst_id", 32'(OUT_ID), 32'h0);
        check_eq("rst_err", 32'(ERR), 32'h0);
        step();
        step();
        REQ_VALID = 2'b00;
        RST = 1'b0;
        #1;
        check_eq("idle_ack", 32'(REQ_ACK), 32'h0);
        step();
        check_eq("idle_valid", 32'(OUT_VALID), 32'h0);

        // Single request: 0xF0 >> 4.
        set_req(0, 1'b1, 32'h0000_00F0, 5'd4, SEL_RIGHT, 1'b0);
        #1;
        check_eq("single_ack", 32'(REQ_ACK), 32'h1);
        step();
        check_eq("single_out", OUT, 32'h0000_000F);
        check_eq("single_id", 32'(OUT_ID), 32'h0);
        check_eq("single_valid", 32'(OUT_VALID), 32'h1);

        // Requester 1 alone, brings the pointer back to 0: 0x1 << 4.
        REQ_VALID = 2'b00;
        set_req(1, 1'b1, 32'h1, 5'd4, SEL_LEFT, 1'b0);
        #1;
        check_eq("r1_ack", 32'(REQ_ACK), 32'h2);
        step();
        check_eq("r1_out", OUT, 32'h10);
        check_eq("r1_id", 32'(OUT_ID), 32'h1);

        // Contention: req0 = 0x100 >> 8 = 1, req1 = 0x3 << 1 = 6.
        set_req(0, 1'b1, 32'h100, 5'd8, SEL_RIGHT, 1'b0);
        set_req(1, 1'b1, 32'h3, 5'd1, SEL_LEFT, 1'b0);
        exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_out = '{32'h1, 32'h6, 32'h1, 32'h6};
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("cont_ack%0d", k), 32'(REQ_ACK), 32'(exp_ack[k]));
            step();
            check_eq($sformatf("cont_out%0d", k), OUT, exp_out[k]);
            check_eq($sformatf("cont_id%0d", k), 32'(OUT_ID), 32'(k % 2));
        end

        // Backpressure: FULL with ready low holds the result and blocks grants.
        OUT_READY = 1'b0;
        #1;
        check_eq("bp_ack", 32'(REQ_ACK), 32'h0);
        step();
        step();
        check_eq("bp_out", OUT, 32'h6);
        check_eq("bp_id", 32'(OUT_ID), 32'h1);
        check_eq("bp_valid", 32'(OUT_VALID), 32'h1);
        // Drain and refill in one cycle.
        OUT_READY = 1'b1;
        #1;
        check_eq("refill_ack", 32'(REQ_ACK), 32'h1);
        step();
        check_eq("refill_out", OUT, 32'h1);
        check_eq("refill_id", 32'(OUT_ID), 32'h0);
        check_eq("refill_valid", 32'(OUT_VALID), 32'h1);
        REQ_VALID = 2'b00;
        step();
        check_eq("drain_valid", 32'(OUT_VALID), 32'h0);

        // Arithmetic right and sign extensions.
        set_req(0, 1'b1, 32'h8000_0000, 5'd31, SEL_RIGHT, 1'b1);
        #1;
        check_eq("asr_ack", 32'(REQ_ACK), 32'h1);
        step();
        check_eq("asr_out", OUT, 32'hFFFF_FFFF);
        set_req(0, 1'b1, 32'h8000_0000, 5'd31, SEL_RIGHT, 1'b0);
        step();
        check_eq("lsr_out", OUT, 32'h0000_0001);
        set_req(0, 1'b1, 32'h0000_0080, 5'd0, SEL_SEXT8, 1'b0);
        step();
        check_eq("sext8_out", OUT, 32'hFFFF_FF80);
        check_eq("sext8_err", 32'(ERR), 32'h0);
        set_req(0, 1'b1, 32'h0000_8000, 5'd0, SEL_SEXT16, 1'b0);
        step();
        check_eq("sext16_out", OUT, 32'hFFFF_8000);

        // Reset mid-operation while FULL (pointer is at 1 here).
        OUT_READY = 1'b0;
        REQ_VALID = 2'b00;
        step();
        #1;
        RST = 1'b1;
        #1;
        check_eq("mrst_valid", 32'(OUT_VALID), 32'h0);
        check_eq("mrst_out", OUT, 32'h0);
        REQ_VALID = 2'b11;
        #1;
        check_eq("mrst_ack", 32'(REQ_ACK), 32'h0);
        RST = 1'b0;
        #1;
        check_eq("mrst_ptr_ack", 32'(REQ_ACK), 32'h1);
        step();
        check_eq("mrst_out2", OUT, 32'hFFFF_8000);
        check_eq("mrst_id2", 32'(OUT_ID), 32'h0);

        // Illegal op: left with ARITH. Result is still 1 << 3.
`ifdef SHIFTER_ARB_CHECK_EN
        exp_err = 32'h1;
`else
        exp_err = 32'h0;
`endif
        OUT_READY = 1'b1;
        REQ_VALID = 2'b00;
        set_req(1, 1'b1, 32'h1, 5'd3, SEL_LEFT, 1'b1);
        #1;
        check_eq("ill_ack", 32'(REQ_ACK), 32'h2);
        step();
        check_eq("ill_out", OUT, 32'h8);
        check_eq("ill_err", 32'(ERR), exp_err);
        // Signext with shift amount: same result either way.
        set_req(1, 1'b1, 32'h0000_00C3, 5'd4, SEL_SEXT8, 1'b0);
        step();
        check_eq("ill_sx_out", OUT, 32'hFFFF_FFC3);
        check_eq("ill_sx_err", 32'(ERR), exp_err);
        // Legal op clears ERR.
        set_req(1, 1'b1, 32'h8, 5'd1, SEL_RIGHT, 1'b0);
        step();
        check_eq("legal_out", OUT, 32'h4);
        check_eq("legal_err", 32'(ERR), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
